pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequencing controller for the 8-bit five-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
//  Drives per-stage enables and bubble/flush controls for load-use stalls, taken-branch flushes,
//  multi-cycle data-memory waits and HALT. Also drives EX operand forwarding selects.
// PARAMETERS
//  MEM_LAT  2  wait cycles added per data-memory access (0 = single-cycle memory, no WAIT state)
//  CNT_W    4  width of the wait counter; must satisfy MEM_LAT < 2**CNT_W
// PORTS
//  clk         in  1  pipeline clock, rising edge
//  rst         in  1  asynchronous, active-high reset
//  id_rs1      in  3  source reg 1 of the instruction in ID
//  id_rs2      in  3  source reg 2 of the instruction in ID
//  id_use1     in  1  ID instruction reads rs1
//  id_use2     in  1  ID instruction reads rs2
//  ex_rs1      in  3  source reg 1 of the instruction in EX (forwarding)
//  ex_rs2      in  3  source reg 2 of the instruction in EX (forwarding)
//  ex_memrd    in  1  EX instruction is a load
//  ex_wreg     in  3  EX destination reg
//  ex_br_taken in  1  branch resolved taken in EX
//  mem_acc     in  1  MEM instruction is a load or store
//  mem_regwr   in  1  MEM instruction writes the register file
//  mem_wreg    in  3  MEM destination reg
//  wb_regwr    in  1  WB instruction writes the register file
//  wb_wreg     in  3  WB destination reg
//  wb_halt     in  1  HLT opcode reached WB
//  pc_en       out 1  PC load enable
//  ifid_en     out 1  IF/ID load enable
//  ifid_flush  out 1  IF/ID loads a NOP
//  idex_en     out 1  ID/EX load enable
//  idex_bubble out 1  ID/EX loads a NOP (controls cleared)
//  exmem_en    out 1  EX/MEM load enable
//  memwb_bubble out 1 MEM/WB loads regwr=0 (MEM/WB is always clocked)
//  fwd_a       out 2  EX operand A select: 0 = regfile, 1 = MEM ALU result, 2 = WB write data
//  fwd_b       out 2  EX operand B select, same encoding
//  state       out 2  0 = RUN, 1 = WAIT, 2 = HALT
//  stall_cyc   out 16 stall-cycle counter (see CONFIGURATION)
//  flush_cnt   out 16 taken-branch flush counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state = RUN, cnt = 0, served = 0, counters = 0. All stage outputs take their RUN values, evaluated live from the inputs.
//  - RUN, default: all enables = 1; bubble and flush outputs = 0.
//  - WAIT entry: in RUN with mem_acc=1, served=0 and MEM_LAT>0, the current cycle is a freeze cycle.
//    Next state = WAIT; cnt loads MEM_LAT-1.
//  - Freeze: pc_en, ifid_en, idex_en and exmem_en = 0; memwb_bubble = 1.
//  - WAIT: freeze every cycle. cnt decrements; when cnt == 0, go to RUN and set served = 1.
//    Total stall = MEM_LAT cycles.
//  - served: while set, RUN ignores mem_acc. It clears on the first cycle with exmem_en=1.
//  - Load-use (RUN, no freeze): ex_memrd=1 and (id_use1 && id_rs1==ex_wreg || id_use2 && id_rs2==ex_wreg).
//    Response: pc_en = 0, ifid_en = 0, idex_bubble = 1 for exactly 1 cycle.
//  - Branch (RUN, no freeze): ex_br_taken=1 -> ifid_flush = 1 and idex_bubble = 1; pc_en = 1 (PC loads target).
//  - Priority: freeze > branch > load-use. A branch held during a freeze is re-evaluated on release.
//    A load-use hazard coinciding with a taken branch is dropped, because its consumer is flushed.
//  - HALT: wb_halt=1 in any state -> next state HALT. All enables = 0, memwb_bubble = 1 until rst.
//  - Forwarding (combinational, all 8 regs, no hardwired zero):
//    fwd_a = 1 if mem_regwr && mem_wreg==ex_rs1; else 2 if wb_regwr && wb_wreg==ex_rs1; else 0.
//    MEM has priority over WB. fwd_b is the same using ex_rs2.
//  - Reset mid-WAIT aborts the wait immediately; the outputs return to their RUN values.
// CONFIGURATION
//  PIPE_HAZARD_CTRL_PERF_EN defined:
//   - stall_cyc increments on every freeze or load-use cycle.
//   - flush_cnt increments on every taken-branch flush.
//   - Both counters saturate at 16'hFFFF and reset to 0.
//  Undefined: stall_cyc and flush_cnt are tied to 0 and no counter logic is built. Ports stay present.
// TESTING
//  1. Reset, idle inputs -> state=0; pc_en, ifid_en, idex_en, exmem_en = 1; bubble and flush outputs = 0; fwd_a = fwd_b = 0.
//  2. ex_memrd=1, ex_wreg=3, id_rs2=3, id_use2=1 -> one cycle pc_en=0, ifid_en=0, idex_bubble=1; RUN values the next cycle.
//  3. MEM_LAT=2, mem_acc=1 held -> freeze for 2 cycles (state 0 then 1), exmem_en=1 on the 3rd cycle, no re-freeze.
//  4. ex_br_taken=1 together with a load-use hazard -> ifid_flush=1, idex_bubble=1, pc_en=1; flush_cnt +1 with PERF_EN.
//  5. mem_regwr=1, mem_wreg=5, wb_regwr=1, wb_wreg=5, ex_rs1=5 -> fwd_a=1; then mem_regwr=0 -> fwd_a=2.
//  6. rst pulse while in WAIT (cnt=1) -> asynchronous return to RUN; wb_halt=1 -> state=2, frozen until rst.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Sequencing controller for the 8-bit five-stage pipeline. It produces the
//   per-stage load enables and the bubble/flush controls that handle four cases:
//   load-use stalls, taken-branch flushes, multi-cycle data-memory waits and HALT.
//   It also produces the EX operand forwarding selects.
//
//   Parameters
//     MEM_LAT  wait cycles added per data-memory access (0 = single-cycle memory)
//     CNT_W    wait counter width, MEM_LAT < 2**CNT_W
//
//   Ports
//     clk, rst                 clock (rising edge), asynchronous active-high reset
//     id_rs1/2, id_use1/2      source registers of the ID instruction and their use flags
//     ex_rs1/2                 source registers of the EX instruction (forwarding)
//     ex_memrd, ex_wreg        EX instruction is a load, and its destination
//     ex_br_taken              branch resolved taken in EX
//     mem_acc                  MEM instruction accesses data memory
//     mem_regwr, mem_wreg      MEM register write-back enable and destination
//     wb_regwr, wb_wreg        WB register write-back enable and destination
//     wb_halt                  HLT reached WB
//     pc_en .. memwb_bubble    stage enables and bubble/flush controls
//     fwd_a, fwd_b             0 = regfile, 1 = MEM ALU result, 2 = WB write data
//     state                    0 = RUN, 1 = WAIT, 2 = HALT
//     stall_cyc, flush_cnt     performance counters
//
//   Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN
//     When it is defined, the saturating stall-cycle and flush counters are built.
//     When it is not defined, both counter outputs are tied to zero.

module pipe_hazard_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_rs1,
  input  logic [2:0]  id_rs2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic [2:0]  ex_rs1,
  input  logic [2:0]  ex_rs2,
  input  logic        ex_memrd,
  input  logic [2:0]  ex_wreg,
  input  logic        ex_br_taken,
  input  logic        mem_acc,
  input  logic        mem_regwr,
  input  logic [2:0]  mem_wreg,
  input  logic        wb_regwr,
  input  logic [2:0]  wb_wreg,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_bubble,
  output logic        exmem_en,
  output logic        memwb_bubble,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  state,
  output logic [15:0] stall_cyc,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // The freeze cycle in RUN is the first stall cycle. WAIT therefore covers
  // the remaining MEM_LAT-1 cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             served_q, served_d;

  logic mem_start;
  logic freeze;
  logic hazard;
  logic branch;
  logic load_use;

  // Hazard classification. The priority order is freeze, then branch, then load-use.
  // A load-use hazard that coincides with a taken branch is dropped, because
  // its consumer is flushed anyway.
  always_comb begin
    mem_start = (state_q == ST_RUN) && mem_acc && !served_q && (MEM_LAT > 0);
    freeze    = (state_q == ST_WAIT) || mem_start;
    hazard    = ex_memrd && ((id_use1 && (id_rs1 == ex_wreg)) ||
                             (id_use2 && (id_rs2 == ex_wreg)));
    branch    = (state_q == ST_RUN) && !freeze && ex_br_taken;
    load_use  = (state_q == ST_RUN) && !freeze && !ex_br_taken && hazard;
  end

  // Stage controls are combinational. They follow the current state and the
  // live inputs, so the RUN values are visible during reset as well.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    if (state_q == ST_HALT || freeze) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (branch) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Forwarding covers all eight registers, because r0 is not hardwired to zero.
  // The younger MEM result takes priority over WB.
  always_comb begin
    fwd_a = 2'd0;
    fwd_b = 2'd0;
    if (mem_regwr && (mem_wreg == ex_rs1))     fwd_a = 2'd1;
    else if (wb_regwr && (wb_wreg == ex_rs1))  fwd_a = 2'd2;
    if (mem_regwr && (mem_wreg == ex_rs2))     fwd_b = 2'd1;
    else if (wb_regwr && (wb_wreg == ex_rs2))  fwd_b = 2'd2;
  end

  // Next-state logic. The served flag stops the access that was just waited
  // for from freezing the pipe again. It clears when EX/MEM next advances.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    served_d = served_q;
    if (exmem_en) served_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_start) begin
          if (MEM_LAT == 1) begin
            served_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          served_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
    if (wb_halt) state_d = ST_HALT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      served_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      served_q <= served_d;
    end
  end

  assign state = state_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [15:0] stall_cyc_q, stall_cyc_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate, so that a long run cannot wrap them back to small values.
  always_comb begin
    stall_cyc_d = stall_cyc_q;
    flush_cnt_d = flush_cnt_q;
    if ((freeze || load_use) && (stall_cyc_q != 16'hFFFF))
      stall_cyc_d = stall_cyc_q + 16'd1;
    if (branch && (flush_cnt_q != 16'hFFFF))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cyc = stall_cyc_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cyc = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ctrl packing: {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble}
  localparam logic [6:0] C_RUN = 7'b1101010;
  localparam logic [6:0] C_FRZ = 7'b0000001;
  localparam logic [6:0] C_LU  = 7'b0001110;
  localparam logic [6:0] C_BR  = 7'b1111110;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_wreg, mem_wreg, wb_wreg;
  logic        id_use1, id_use2, ex_memrd, ex_br_taken, mem_acc;
  logic        mem_regwr, wb_regwr, wb_halt;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble;
  logic [1:0]  fwd_a, fwd_b, state;
  logic [15:0] stall_cyc, flush_cnt;
  logic [6:0]  ctrl;

  int checks = 0;
  int errors = 0;

  assign ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_LAT(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_memrd(ex_memrd), .ex_wreg(ex_wreg),
    .ex_br_taken(ex_br_taken), .mem_acc(mem_acc),
    .mem_regwr(mem_regwr), .mem_wreg(mem_wreg),
    .wb_regwr(wb_regwr), .wb_wreg(wb_wreg), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_bubble(memwb_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .stall_cyc(stall_cyc), .flush_cnt(flush_cnt)
  );

  // Drives the hazard-related inputs, then lets the combinational outputs settle.
  task automatic applyStimulus(input logic memrd, input logic [2:0] wreg,
                               input logic [2:0] rs1, input logic [2:0] rs2,
                               input logic use1, input logic use2,
                               input logic br, input logic macc);
    ex_memrd    = memrd;
    ex_wreg     = wreg;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_use1     = use1;
    id_use2     = use2;
    ex_br_taken = br;
    mem_acc     = macc;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    ex_rs1 = 3'd1; ex_rs2 = 3'd2;
    mem_regwr = 1'b0; mem_wreg = 3'd0;
    wb_regwr = 1'b0; wb_wreg = 3'd0; wb_halt = 1'b0;
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #11;
    $display("[TB] reset state");
    checkOutput("rst_ctrl", {9'd0, ctrl}, {9'd0, C_RUN});
    rst = 1'b0;
    #1;
    checkOutput("idle_state", {14'd0, state}, 16'd0);
    checkOutput("idle_ctrl", {9'd0, ctrl}, {9'd0, C_RUN});
    checkOutput("idle_fwd", {12'd0, fwd_a, fwd_b}, 16'd0);
    checkOutput("idle_stall", stall_cyc, 16'd0);
    checkOutput("idle_flush", flush_cnt, 16'd0);

    $display("[TB] forwarding");
    mem_regwr = 1'b1; mem_wreg = 3'd5; wb_regwr = 1'b1; wb_wreg = 3'd5; ex_rs1 = 3'd5;
    #1 checkOutput("fwd_a_mem", {14'd0, fwd_a}, 16'd1);
    mem_regwr = 1'b0;
    #1 checkOutput("fwd_a_wb", {14'd0, fwd_a}, 16'd2);
    wb_regwr = 1'b0;
    #1 checkOutput("fwd_a_none", {14'd0, fwd_a}, 16'd0);
    mem_regwr = 1'b1; mem_wreg = 3'd0; ex_rs1 = 3'd0; ex_rs2 = 3'd0;
    wb_regwr = 1'b1; wb_wreg = 3'd6;
    #1 checkOutput("fwd_r0_ab", {12'd0, fwd_a, fwd_b}, 16'h5);
    ex_rs2 = 3'd6;
    #1 checkOutput("fwd_b_wb", {14'd0, fwd_b}, 16'd2);
    mem_regwr = 1'b0; wb_regwr = 1'b0; ex_rs1 = 3'd1; ex_rs2 = 3'd2;

    $display("[TB] load-use");
    applyStimulus(1'b1, 3'd3, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_unused_rs2", {9'd0, ctrl}, {9'd0, C_RUN});
    applyStimulus(1'b1, 3'd3, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lu_rs2", {9'd0, ctrl}, {9'd0, C_LU});
    step();
    applyStimulus(1'b0, 3'd3, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lu_after", {9'd0, ctrl}, {9'd0, C_RUN});
    checkOutput("lu_stall_cnt", stall_cyc, PERF ? 16'd1 : 16'd0);
    applyStimulus(1'b1, 3'd7, 3'd7, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs1", {9'd0, ctrl}, {9'd0, C_LU});
    step();

    $display("[TB] branch with load-use");
    applyStimulus(1'b1, 3'd3, 3'd0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("br_lu_ctrl", {9'd0, ctrl}, {9'd0, C_BR});
    step();
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("br_flush_cnt", flush_cnt, PERF ? 16'd1 : 16'd0);
    checkOutput("br_stall_cnt", stall_cyc, PERF ? 16'd2 : 16'd0);

    $display("[TB] memory wait");
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("mw1_state", {14'd0, state}, 16'd0);
    checkOutput("mw1_ctrl", {9'd0, ctrl}, {9'd0, C_FRZ});
    step();
    checkOutput("mw2_state", {14'd0, state}, 16'd1);
    checkOutput("mw2_ctrl", {9'd0, ctrl}, {9'd0, C_FRZ});
    step();
    checkOutput("mw3_state", {14'd0, state}, 16'd0);
    checkOutput("mw3_ctrl", {9'd0, ctrl}, {9'd0, C_RUN});
    step();
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mw_stall_cnt", stall_cyc, PERF ? 16'd4 : 16'd0);

    $display("[TB] branch held through a freeze");
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("hb1_ctrl", {9'd0, ctrl}, {9'd0, C_FRZ});
    step();
    checkOutput("hb2_ctrl", {9'd0, ctrl}, {9'd0, C_FRZ});
    step();
    checkOutput("hb3_ctrl", {9'd0, ctrl}, {9'd0, C_BR});
    step();
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("hb_flush_cnt", flush_cnt, PERF ? 16'd2 : 16'd0);

    $display("[TB] reset during wait");
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("rw_wait_state", {14'd0, state}, 16'd1);
    mem_acc = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rw_state", {14'd0, state}, 16'd0);
    checkOutput("rw_ctrl", {9'd0, ctrl}, {9'd0, C_RUN});
    checkOutput("rw_stall", stall_cyc, 16'd0);
    rst = 1'b0;
    step();
    checkOutput("rw_after_state", {14'd0, state}, 16'd0);

    $display("[TB] halt");
    wb_halt = 1'b1;
    #1 checkOutput("halt_pre_ctrl", {9'd0, ctrl}, {9'd0, C_RUN});
    step();
    wb_halt = 1'b0;
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("halt_state", {14'd0, state}, 16'd2);
    checkOutput("halt_ctrl", {9'd0, ctrl}, {9'd0, C_FRZ});
    step();
    checkOutput("halt_hold", {14'd0, state}, 16'd2);
    checkOutput("halt_hold_ctrl", {9'd0, ctrl}, {9'd0, C_FRZ});
    checkOutput("halt_no_flush", flush_cnt, 16'd0);
    rst = 1'b1;
    #1;
    checkOutput("halt_rst_state", {14'd0, state}, 16'd0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
